// File: rtl/mct_result_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mct_result_packer_if
//  Brief    : Engine-side result stream and write-master line stream bundle.
//  Revision : 1.0
// ============================================================================
interface mct_result_packer_if #(
  parameter int G_DATA_BUS_WIDTH = 512,
  parameter int G_RESULT_WIDTH   = 16
);
  logic                        start_i;
  logic [31:0]                 expected_cls_i;
  logic [G_RESULT_WIDTH-1:0]   res_data_i;
  logic                        res_valid_i;
  logic                        res_last_i;
  logic                        res_ready_o;
  logic [G_DATA_BUS_WIDTH-1:0] wr_data_o;
  logic                        wr_valid_o;
  logic                        wr_ready_i;
  logic [31:0]                 cls_written_o;
  logic                        overflow_o;
  logic                        done_o;

  modport slave (
    input  start_i, expected_cls_i, res_data_i, res_valid_i, res_last_i, wr_ready_i,
    output res_ready_o, wr_data_o, wr_valid_o, cls_written_o, overflow_o, done_o
  );

  modport master (
    output start_i, expected_cls_i, res_data_i, res_valid_i, res_last_i, wr_ready_i,
    input  res_ready_o, wr_data_o, wr_valid_o, cls_written_o, overflow_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/mct_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : mct_result_packer
//  Brief    : Packs engine result words into bus lines, pads to a line budget.
//  Revision : 1.0
// ============================================================================
module mct_result_packer #(
  parameter int                      G_DATA_BUS_WIDTH = 512,
  parameter int                      G_RESULT_WIDTH   = 16,
  parameter logic [G_RESULT_WIDTH-1:0] G_PAD_VALUE    = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  mct_result_packer_if.slave  pk_if
);

  localparam int c_SLOTS  = G_DATA_BUS_WIDTH / G_RESULT_WIDTH;
  localparam int c_SLOT_W = $clog2(c_SLOTS) + 1;
  localparam logic [c_SLOT_W-1:0]         c_LAST_SLOT = c_SLOT_W'(c_SLOTS - 1);
  localparam logic [G_DATA_BUS_WIDTH-1:0] c_PAD_LINE  = {c_SLOTS{G_PAD_VALUE}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [31:0]                 r_budget, r_issued, r_cls_written;
  logic                        r_overflow;
  logic [G_DATA_BUS_WIDTH-1:0] r_asm, w_asm_next;
  logic [c_SLOT_W-1:0]         r_slot;
  logic                        r_pend;
  logic [G_DATA_BUS_WIDTH-1:0] r_out_data, w_load_data;
  logic                        r_out_valid;

  logic w_o_free, w_at_budget, w_res_ready, w_store, w_complete;
  logic w_load, w_release, w_drop, w_start_ok;

  // The assembly register is preloaded with padding, so unwritten slots need no fix-up.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[int'(r_slot)*G_RESULT_WIDTH +: G_RESULT_WIDTH] = pk_if.res_data_i;
  end

  always_comb begin
    w_o_free    = !r_out_valid || pk_if.wr_ready_i;
    w_at_budget = (r_issued == r_budget);
    w_start_ok  = pk_if.start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_res_ready = 1'b0;
    w_store     = 1'b0;
    w_complete  = 1'b0;
    w_load      = 1'b0;
    w_load_data = c_PAD_LINE;
    w_release   = 1'b0;
    w_drop      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (pk_if.start_i)
          w_state_nxt = (pk_if.expected_cls_i == 32'd0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        w_res_ready = !r_pend;
        if (r_pend) begin
          if (w_o_free) begin
            w_release   = 1'b1;
            w_load      = 1'b1;
            w_load_data = r_asm;
          end
        end else if (pk_if.res_valid_i) begin
          if (w_at_budget) begin
            w_drop = 1'b1;
          end else begin
            w_store    = 1'b1;
            w_complete = (r_slot == c_LAST_SLOT) || pk_if.res_last_i;
            if (w_complete && w_o_free) begin
              w_load      = 1'b1;
              w_load_data = w_asm_next;
            end
          end
          if (pk_if.res_last_i)
            w_state_nxt = S_PAD;
        end
      end
      S_PAD: begin
        // A line still pending from the final word goes out before any padding.
        if (r_pend) begin
          if (w_o_free) begin
            w_release   = 1'b1;
            w_load      = 1'b1;
            w_load_data = r_asm;
          end
        end else if (!w_at_budget) begin
          w_load = w_o_free;
        end else if (w_o_free) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_res_ready = 1'b1;
        w_drop      = pk_if.res_valid_i;
        if (pk_if.start_i)
          w_state_nxt = (pk_if.expected_cls_i == 32'd0) ? S_DONE : S_FILL;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_budget      <= 32'd0;
      r_issued      <= 32'd0;
      r_cls_written <= 32'd0;
      r_overflow    <= 1'b0;
      r_asm         <= c_PAD_LINE;
      r_slot        <= '0;
      r_pend        <= 1'b0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
      end else if (pk_if.wr_ready_i) begin
        r_out_valid <= 1'b0;
      end

      if (w_start_ok) begin
        r_budget      <= pk_if.expected_cls_i;
        r_issued      <= 32'd0;
        r_cls_written <= 32'd0;
        r_overflow    <= 1'b0;
        r_asm         <= c_PAD_LINE;
        r_slot        <= '0;
        r_pend        <= 1'b0;
      end else begin
        if (w_load)
          r_issued <= r_issued + 32'd1;
        if (r_out_valid && pk_if.wr_ready_i)
          r_cls_written <= r_cls_written + 32'd1;
        if (w_drop)
          r_overflow <= 1'b1;
        if (w_release) begin
          r_pend <= 1'b0;
          r_asm  <= c_PAD_LINE;
        end else if (w_store) begin
          if (w_complete) begin
            r_slot <= '0;
            if (w_o_free) begin
              r_asm <= c_PAD_LINE;
            end else begin
              r_asm  <= w_asm_next;
              r_pend <= 1'b1;
            end
          end else begin
            r_asm  <= w_asm_next;
            r_slot <= r_slot + c_SLOT_W'(1);
          end
        end
      end
    end
  end

  assign pk_if.res_ready_o   = w_res_ready;
  assign pk_if.wr_data_o     = r_out_data;
  assign pk_if.wr_valid_o    = r_out_valid;
  assign pk_if.cls_written_o = r_cls_written;
  assign pk_if.overflow_o    = r_overflow;
  assign pk_if.done_o        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mct_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mct_result_packer
//  Brief    : Scoreboard bench for mct_result_packer with directed job vectors.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mct_result_packer;

  localparam int W  = 16;
  localparam int DW = 512;
  localparam int SL = DW / W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mct_result_packer_if #(.G_DATA_BUS_WIDTH(DW), .G_RESULT_WIDTH(W)) pk_if ();

  mct_result_packer #(.G_DATA_BUS_WIDTH(DW), .G_RESULT_WIDTH(W), .G_PAD_VALUE(16'hFFFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pk_if (pk_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_hs_cyc = 0;
  int wr_mode  = 0;
  int stall_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pad_line;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && pk_if.wr_valid_o) begin
      if (prev_stall) chk("stable_while_stalled", pk_if.wr_data_o, prev_data);
      if (pk_if.wr_ready_i) begin
        last_hs_cyc = cyc;
        chk("line_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("line_data", pk_if.wr_data_o, exp_q.pop_front());
      end
    end
    prev_stall = rst_n && pk_if.wr_valid_o && !pk_if.wr_ready_i;
    prev_data  = pk_if.wr_data_o;
  end

  initial begin
    pk_if.wr_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (wr_mode)
        0:       pk_if.wr_ready_i = 1'b1;
        1:       pk_if.wr_ready_i = 1'($urandom_range(0, 1));
        default: pk_if.wr_ready_i = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent packing model: slot 0 in the LSBs, padding after last, budget cap.
  task automatic push_exp(input int budget, input int words[$]);
    logic [DW-1:0] line;
    int lines = 0;
    int slot  = 0;
    line = pad_line;
    for (int i = 0; i < words.size(); i++) begin
      line[slot*W +: W] = words[i][W-1:0];
      slot++;
      if (slot == SL || i == words.size() - 1) begin
        if (lines < budget) begin
          exp_q.push_back(line);
          lines++;
        end
        line = pad_line;
        slot = 0;
      end
    end
    while (lines < budget) begin
      exp_q.push_back(pad_line);
      lines++;
    end
  endtask

  task automatic send_word(input int d, input logic last);
    int t = 0;
    pk_if.res_valid_i = 1'b1;
    pk_if.res_data_i  = d[W-1:0];
    pk_if.res_last_i  = last;
    forever begin
      @(negedge clk);
      if (pk_if.res_ready_o) break;
      stall_cnt++;
      t++;
      if (t > 2000) begin
        fail_now("accept_timeout");
        break;
      end
    end
    @(posedge clk); #1;
    pk_if.res_valid_i = 1'b0;
    pk_if.res_last_i  = 1'b0;
  endtask

  task automatic send_seq(input int words[$], input bit with_last);
    for (int i = 0; i < words.size(); i++)
      send_word(words[i], with_last && (i == words.size() - 1));
  endtask

  task automatic start_job(input int budget);
    pk_if.start_i        = 1'b1;
    pk_if.expected_cls_i = budget;
    @(posedge clk); #1;
    pk_if.start_i = 1'b0;
  endtask

  task automatic wait_done(input bit check_timing);
    int t = 0;
    forever begin
      @(negedge clk);
      if (pk_if.done_o) break;
      t++;
      if (t > 5000) begin
        fail_now("done_timeout");
        break;
      end
    end
    if (check_timing) chk("done_timing", cyc, last_hs_cyc + 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int w[$];
    pad_line = {SL{16'hFFFF}};
    rst_n = 1'b0;
    pk_if.start_i = 1'b0;
    pk_if.expected_cls_i = 32'd0;
    pk_if.res_data_i = '0;
    pk_if.res_valid_i = 1'b0;
    pk_if.res_last_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_ready", pk_if.res_ready_o, 0);
    chk("rst_wr_valid", pk_if.wr_valid_o, 0);
    chk("rst_wr_data", pk_if.wr_data_o, 0);
    chk("rst_cls_written", pk_if.cls_written_o, 0);
    chk("rst_overflow", pk_if.overflow_o, 0);
    chk("rst_done", pk_if.done_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two exactly full lines, no padding.
    w = {};
    for (int i = 0; i < 64; i++) w.push_back(i);
    push_exp(2, w);
    start_job(2);
    chk("t1_ready_after_start", pk_if.res_ready_o, 1);
    stall_cnt = 0;
    send_seq(w, 1'b1);
    chk("t1_no_bubble", stall_cnt, 0);
    wait_done(1'b1);
    chk("t1_cls_written", pk_if.cls_written_o, 2);
    chk("t1_overflow", pk_if.overflow_o, 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // Short job padded up to three lines.
    w = {1, 2, 3, 4, 5};
    push_exp(3, w);
    start_job(3);
    send_seq(w, 1'b1);
    wait_done(1'b1);
    chk("t2_cls_written", pk_if.cls_written_o, 3);
    chk("t2_overflow", pk_if.overflow_o, 0);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Excess results beyond a one-line budget are dropped.
    w = {};
    for (int i = 1; i <= 40; i++) w.push_back(i);
    push_exp(1, w);
    start_job(1);
    send_seq(w, 1'b1);
    wait_done(1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_overflow", pk_if.overflow_o, 1);
    chk("t3_cls_written", pk_if.cls_written_o, 1);
    chk("t3_done", pk_if.done_o, 1);
    chk("t3_sb_empty", exp_q.size(), 0);

    // Random backpressure with a long stall window.
    w = {};
    for (int i = 0; i < 4 * SL; i++) w.push_back(16'h1000 + i);
    push_exp(4, w);
    start_job(4);
    stall_cnt = 0;
    wr_mode = 1;
    fork
      send_seq(w, 1'b1);
      begin
        repeat (20) @(posedge clk);
        wr_mode = 2;
        repeat (50) @(posedge clk);
        wr_mode = 1;
      end
    join
    wait_done(1'b1);
    wr_mode = 0;
    chk("t4_backpressure_seen", stall_cnt > 0, 1);
    chk("t4_cls_written", pk_if.cls_written_o, 4);
    chk("t4_overflow", pk_if.overflow_o, 0);
    chk("t4_sb_empty", exp_q.size(), 0);
    @(posedge clk); #1;

    // Zero budget, then re-arm with a one-word job.
    start_job(0);
    chk("t5_done_budget0", pk_if.done_o, 1);
    chk("t5_no_valid", pk_if.wr_valid_o, 0);
    w = {16'hABCD};
    push_exp(1, w);
    start_job(1);
    chk("t5_done_cleared", pk_if.done_o, 0);
    send_seq(w, 1'b1);
    wait_done(1'b1);
    chk("t5_cls_written", pk_if.cls_written_o, 1);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Reset mid-fill discards the partial line.
    start_job(2);
    w = {};
    for (int i = 1; i <= 10; i++) w.push_back(i);
    send_seq(w, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_res_ready", pk_if.res_ready_o, 0);
    chk("t6_rst_wr_valid", pk_if.wr_valid_o, 0);
    chk("t6_rst_wr_data", pk_if.wr_data_o, 0);
    chk("t6_rst_done", pk_if.done_o, 0);
    chk("t6_rst_overflow", pk_if.overflow_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    w = {};
    for (int i = 0; i < SL; i++) w.push_back(200 + i);
    push_exp(1, w);
    start_job(1);
    send_seq(w, 1'b1);
    wait_done(1'b1);
    chk("t6_cls_written", pk_if.cls_written_o, 1);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mct_result_packer.md
# mct_result_packer

Stream stage between the MCT engine core and the AXI4 write master. Collects narrow per-query result words from the engine and packs them into full data-bus lines in arrival order. After the engine's final result, it pads the output with filler lines until exactly the programmed number of lines has been emitted, so the write master's fixed transfer size always completes. Sticky status bits report excess results so the engine never deadlocks.

## Interface
- G_DATA_BUS_WIDTH, 512, output line width in bits; must be a multiple of G_RESULT_WIDTH.
- G_RESULT_WIDTH, 16, width of one engine result word.
- G_PAD_VALUE, all-ones (G_RESULT_WIDTH bits), filler value for unused slots and padding lines.
- Derived: SLOTS = G_DATA_BUS_WIDTH / G_RESULT_WIDTH (32 with defaults); slot counter is clog2(SLOTS)+1 bits.
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start_i  in  1  one-cycle start pulse (driven by ap_start_pulse).
- expected_cls_i  in  32  lines to emit; sampled on start_i (resultNumCLs).
- res_data_i  in  G_RESULT_WIDTH  result word from engine.
- res_valid_i  in  1  result word valid.
- res_last_i  in  1  marks the final result of the job; qualified by res_valid_i.
- res_ready_o  out  1  packer accepts res_data_i this cycle.
- wr_data_o  out  G_DATA_BUS_WIDTH  packed line to write master.
- wr_valid_o  out  1  line valid.
- wr_ready_i  in  1  write master accepts line.
- cls_written_o  out  32  lines accepted downstream since start.
- overflow_o  out  1  sticky; results arrived beyond the line budget and were dropped.
- done_o  out  1  level; all expected lines accepted downstream.

## Operation
- States: IDLE, FILL, PAD, DONE.
- IDLE: res_ready_o=0, wr_valid_o=0.
  - start_i with expected_cls_i=0 -> DONE.
  - start_i with any other value -> FILL; latches budget, clears counters, overflow_o and done_o.
- FILL: each accepted word goes into slot k of the assembly register A, bits [k*W +: W], k = 0..SLOTS-1. Slot 0 is the least significant.
- A completes when slot SLOTS-1 is written or res_last_i is accepted. On completion, slots not written are set to G_PAD_VALUE.
- A completed line transfers to the output register O if O is empty or is being drained that cycle. Otherwise A holds a pending line and res_ready_o=0 until the transfer happens.
- Last accepted and its line transferred:
  - lines issued < budget -> PAD;
  - lines issued = budget -> wait for drain, then DONE.
- Budget reached in FILL without last: further lines are not issued. res_ready_o=1, words are discarded, overflow_o=1. On last -> DONE once O drains.
- PAD: issues all-G_PAD_VALUE lines through O until lines issued = budget; after the final drain -> DONE.
- DONE: done_o=1. res_ready_o=1; any word accepted here is discarded and sets overflow_o. start_i re-arms as in IDLE.
- start_i in FILL or PAD is ignored.
- cls_written_o increments on each wr_valid_o & wr_ready_i; 32-bit, no wrap within a job.

## Timing
- Reset values: res_ready_o=0, wr_valid_o=0, wr_data_o=0, cls_written_o=0, overflow_o=0, done_o=0; state IDLE.
- res_ready_o rises the cycle after start_i.
- Latency: the word that completes a line (SLOTS-th word, or last) is accepted in cycle t; wr_valid_o=1 in cycle t+1 if O was free.
- Output handshake is AXI-Stream style. wr_data_o is stable and wr_valid_o held until wr_ready_i; no combinational path from wr_ready_i to wr_valid_o.
- The path wr_ready_i -> res_ready_o is permitted, for pending-line release only.
- Throughput: one result word per cycle sustained with wr_ready_i=1; a full-speed line every SLOTS cycles with no bubble.
- PAD issues one line per cycle while wr_ready_i=1.
- done_o rises the cycle after the handshake of line number budget. For budget 0, done_o rises the cycle after start_i.
- Reset mid-operation returns everything to reset values next cycle; a partial line is discarded.
- res_last_i is honoured even if it lands in slot SLOTS-1; no extra empty line is generated.

## Test plan
- Budget 2, 64 words 0..63 with last on word 63, wr_ready_i=1 -> line0 slots = 0..31, line1 slots = 32..63, no PAD; done_o one cycle after second handshake; overflow_o=0.
- Budget 3, 5 words 1..5 with last on word 5 -> line0 = 1..5 then 27 × 16'hFFFF; lines 1–2 all-ones; cls_written_o=3, done_o=1.
- Budget 1, 40 words with last on word 40 -> one line (words 1–32); words 33–40 accepted and dropped; overflow_o=1, done_o=1, no further wr_valid_o.
- Budget 4, continuous input, wr_ready_i toggled randomly and held low for 50 cycles -> no word lost or duplicated, wr_data_o stable while stalled, res_ready_o drops only while a line is pending.
- Budget 0 -> done_o high the cycle after start_i, wr_valid_o never asserted. A second start_i with budget 1 plus one word with last -> line {31 × FFFF, word}, done_o re-asserts.
- rst_n low for 1 cycle mid-FILL after 10 words -> all outputs reset next cycle; a new start_i produces lines from fresh data only.
